// File: rtl/dest_reg_tracker.sv
// Destination-register tracker: selects the write destination, pipelines it to writeback
// and flags RAW hazards for decode sources. Optional macro: DEST_REG_TRACKER_STATS_EN.
module dest_reg_tracker #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned DEPTH      = 3,
   parameter int unsigned LINK_REG   = 31
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  issue_valid,
   input  logic                  reg_write_en,
   input  logic [REG_ADDR_W-1:0] read_reg_b,
   input  logic [REG_ADDR_W-1:0] rtype_rd,
   input  logic [1:0]            rd_select,
   input  logic                  stall,
   input  logic                  flush,
   input  logic [REG_ADDR_W-1:0] src_a,
   input  logic [REG_ADDR_W-1:0] src_b,
   output logic [REG_ADDR_W-1:0] write_reg_rd,
   output logic                  hazard_a,
   output logic                  hazard_b,
   output logic                  wb_valid,
   output logic [REG_ADDR_W-1:0] wb_reg
`ifdef DEST_REG_TRACKER_STATS_EN
   ,
   output logic [31:0]           hazard_cycles
`endif
);

   logic [DEPTH-1:0]                 valid_q, valid_d;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] reg_q, reg_d;
   logic [DEPTH-1:0]                 shift_valid;
   logic [DEPTH-1:0][REG_ADDR_W-1:0] shift_reg;
   logic [DEPTH-1:0]                 match_a, match_b;
   logic                             new_valid;

   always_comb begin
      unique case (rd_select)
         2'd0:    write_reg_rd = read_reg_b;
         2'd1:    write_reg_rd = rtype_rd;
         2'd2:    write_reg_rd = REG_ADDR_W'(LINK_REG);
         default: write_reg_rd = '0;
      endcase
   end

   // Register 0 is a hardwired zero, so it is never tracked.
   assign new_valid = issue_valid & reg_write_en & (rd_select != 2'd3) & (write_reg_rd != '0);

   generate
      if (DEPTH == 1) begin : g_shift_single
         assign shift_valid = new_valid;
         assign shift_reg   = write_reg_rd;
      end else begin : g_shift_multi
         assign shift_valid = {valid_q[DEPTH-2:0], new_valid};
         assign shift_reg   = {reg_q[DEPTH-2:0], write_reg_rd};
      end
   endgenerate

   always_comb begin
      valid_d = valid_q;
      reg_d   = reg_q;
      if (flush) begin
         valid_d = '0;
      end else if (!stall) begin
         valid_d = shift_valid;
         reg_d   = shift_reg;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         reg_q   <= '0;
      end else begin
         valid_q <= valid_d;
         reg_q   <= reg_d;
      end
   end

   generate
      for (genvar g = 0; g < DEPTH; g++) begin : g_match
         assign match_a[g] = valid_q[g] & (reg_q[g] == src_a);
         assign match_b[g] = valid_q[g] & (reg_q[g] == src_b);
      end
   endgenerate

   assign hazard_a = (src_a != '0) & (|match_a);
   assign hazard_b = (src_b != '0) & (|match_b);
   assign wb_valid = valid_q[DEPTH-1];
   assign wb_reg   = reg_q[DEPTH-1];

`ifdef DEST_REG_TRACKER_STATS_EN
   logic [31:0] hazard_cycles_q;

   // Counts hazarded issue cycles regardless of stall; only reset clears it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hazard_cycles_q <= '0;
      end else if ((hazard_a | hazard_b) & issue_valid & (hazard_cycles_q != '1)) begin
         hazard_cycles_q <= hazard_cycles_q + 32'd1;
      end
   end

   assign hazard_cycles = hazard_cycles_q;
`endif

endmodule

// File: tb/tb_dest_reg_tracker.sv
// Directed bench for dest_reg_tracker (DEPTH=3, LINK_REG=31) with an in-bench reference model.
module tb_dest_reg_tracker;
   localparam int unsigned W  = 5;
   localparam int unsigned D  = 3;
   localparam int unsigned LR = 31;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         issue_valid = 1'b0;
   logic         reg_write_en = 1'b0;
   logic         stall = 1'b0;
   logic         flush = 1'b0;
   logic [1:0]   rd_select = 2'd3;
   logic [W-1:0] read_reg_b = '0;
   logic [W-1:0] rtype_rd = '0;
   logic [W-1:0] src_a = '0;
   logic [W-1:0] src_b = '0;
   logic [W-1:0] write_reg_rd;
   logic         hazard_a, hazard_b, wb_valid;
   logic [W-1:0] wb_reg;
`ifdef DEST_REG_TRACKER_STATS_EN
   logic [31:0]  hazard_cycles;
`endif

   int vectors = 0;
   int miscompares = 0;

   dest_reg_tracker #(.REG_ADDR_W(W), .DEPTH(D), .LINK_REG(LR)) dut (
      .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .reg_write_en(reg_write_en),
      .read_reg_b(read_reg_b), .rtype_rd(rtype_rd), .rd_select(rd_select), .stall(stall),
      .flush(flush), .src_a(src_a), .src_b(src_b), .write_reg_rd(write_reg_rd),
      .hazard_a(hazard_a), .hazard_b(hazard_b), .wb_valid(wb_valid), .wb_reg(wb_reg)
`ifdef DEST_REG_TRACKER_STATS_EN
      , .hazard_cycles(hazard_cycles)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: list of in-flight entries, youngest first.
   typedef struct packed { bit v; bit [W-1:0] r; } ent_t;
   ent_t      pipe [D];
   bit [31:0] m_hcyc = '0;

   function automatic bit [W-1:0] m_sel();
      bit [W-1:0] link = W'(LR);
      case (rd_select)
         2'd0:    return read_reg_b;
         2'd1:    return rtype_rd;
         2'd2:    return link;
         default: return '0;
      endcase
   endfunction

   function automatic bit m_haz(input bit [W-1:0] s);
      if (s == '0) return 1'b0;
      foreach (pipe[i]) if (pipe[i].v && pipe[i].r == s) return 1'b1;
      return 1'b0;
   endfunction

   initial begin
      foreach (pipe[i]) pipe[i] = '0;
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) begin
            foreach (pipe[i]) pipe[i] = '0;
            m_hcyc = '0;
         end else begin
            if ((m_haz(src_a) || m_haz(src_b)) && issue_valid && m_hcyc != 32'hFFFF_FFFF)
               m_hcyc = m_hcyc + 1;
            if (flush) begin
               foreach (pipe[i]) pipe[i].v = 1'b0;
            end else if (!stall) begin
               ent_t e;
               e.r = m_sel();
               e.v = issue_valid && reg_write_en && rd_select != 2'd3 && e.r != '0;
               for (int i = D - 1; i > 0; i--) pipe[i] = pipe[i-1];
               pipe[0] = e;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, mid-cycle.
   initial begin
      forever begin
         @(negedge clk);
         check("m_write_reg_rd", 32'(write_reg_rd), 32'(m_sel()));
         check("m_hazard_a", 32'(hazard_a), 32'(m_haz(src_a)));
         check("m_hazard_b", 32'(hazard_b), 32'(m_haz(src_b)));
         check("m_wb_valid", 32'(wb_valid), 32'(pipe[D-1].v));
         check("m_wb_reg", 32'(wb_reg), 32'(pipe[D-1].r));
`ifdef DEST_REG_TRACKER_STATS_EN
         check("m_hazard_cycles", hazard_cycles, m_hcyc);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [W-1:0] dest);
      issue_valid = 1'b1; reg_write_en = 1'b1; rd_select = 2'd1; rtype_rd = dest;
   endtask

   task automatic idle();
      issue_valid = 1'b0; reg_write_en = 1'b0; rd_select = 2'd3;
   endtask

   initial begin
      logic [W-1:0] sel_exp [4] = '{5'd5, 5'd6, 5'd31, 5'd0};

      // Reset state
      tick(); tick();
      #1;
      check("rst_wb_valid", 32'(wb_valid), 32'd0);
      check("rst_wb_reg", 32'(wb_reg), 32'd0);
      check("rst_hazard_a", 32'(hazard_a), 32'd0);
      reset_n = 1'b1;
      tick();

      // 1. Selector
      read_reg_b = 5'd5; rtype_rd = 5'd6;
      for (int s = 0; s < 4; s++) begin
         rd_select = 2'(s);
         #1 check("sel", 32'(write_reg_rd), 32'(sel_exp[s]));
      end
      idle();
      tick();

      // 2/3. Latency and hazard window for dest 9
      issue(5'd9); src_a = 5'd9; src_b = '0;
      #1 check("lat_c0_haz_a", 32'(hazard_a), 32'd0);
      tick(); idle();
      #1 check("lat_c1_wb_valid", 32'(wb_valid), 32'd0);
      check("lat_c1_haz_a", 32'(hazard_a), 32'd1);
      check("lat_c1_haz_b", 32'(hazard_b), 32'd0);
      tick();
      #1 check("lat_c2_wb_valid", 32'(wb_valid), 32'd0);
      check("lat_c2_haz_a", 32'(hazard_a), 32'd1);
      tick();
      #1 check("lat_c3_wb_valid", 32'(wb_valid), 32'd1);
      check("lat_c3_wb_reg", 32'(wb_reg), 32'd9);
      check("lat_c3_haz_a", 32'(hazard_a), 32'd1);
      tick();
      #1 check("lat_c4_wb_valid", 32'(wb_valid), 32'd0);
      check("lat_c4_haz_a", 32'(hazard_a), 32'd0);

      // Dest-0 issue is never tracked
      issue(5'd0); src_a = 5'd0;
      tick(); idle();
      #1 check("d0_haz_a", 32'(hazard_a), 32'd0);
      tick(); tick();
      #1 check("d0_wb_valid", 32'(wb_valid), 32'd0);
      tick();

      // 4. Stall
      issue(5'd7); src_a = 5'd7; src_b = 5'd12;
      tick();
      stall = 1'b1; issue(5'd12);
      #1 check("stl_c1_haz_a", 32'(hazard_a), 32'd1);
      tick();
      #1 check("stl_c2_haz_a", 32'(hazard_a), 32'd1);
      check("stl_c2_wb_valid", 32'(wb_valid), 32'd0);
      tick();
      stall = 1'b0; idle();
      #1 check("stl_c3_haz_a", 32'(hazard_a), 32'd1);
      check("stl_c3_haz_b", 32'(hazard_b), 32'd0);
      tick(); tick();
      #1 check("stl_c5_wb_valid", 32'(wb_valid), 32'd1);
      check("stl_c5_wb_reg", 32'(wb_reg), 32'd7);
      check("stl_c5_haz_b", 32'(hazard_b), 32'd0);
      tick();
      #1 check("stl_c6_wb_valid", 32'(wb_valid), 32'd0);

      // 5. Flush overriding stall
      src_a = 5'd5; src_b = 5'd4;
      issue(5'd3); tick();
      issue(5'd4); tick();
      issue(5'd5); tick();
      idle(); flush = 1'b1; stall = 1'b1;
      #1 check("fl_c3_wb_valid", 32'(wb_valid), 32'd1);
      check("fl_c3_wb_reg", 32'(wb_reg), 32'd3);
      check("fl_c3_haz_a", 32'(hazard_a), 32'd1);
      tick();
      flush = 1'b0; stall = 1'b0;
      #1 check("fl_c4_wb_valid", 32'(wb_valid), 32'd0);
      check("fl_c4_haz_a", 32'(hazard_a), 32'd0);
      check("fl_c4_haz_b", 32'(hazard_b), 32'd0);
      tick();

      // 6. Asynchronous reset mid-cycle with entries in flight
      src_a = 5'd10; src_b = 5'd11;
      issue(5'd10); tick();
      issue(5'd11); tick();
      issue(5'd12); tick();
      idle();
      #1 check("ar_pre_wb_valid", 32'(wb_valid), 32'd1);
      check("ar_pre_haz_b", 32'(hazard_b), 32'd1);
      reset_n = 1'b0;
      #1 check("ar_wb_valid", 32'(wb_valid), 32'd0);
      check("ar_wb_reg", 32'(wb_reg), 32'd0);
      check("ar_haz_a", 32'(hazard_a), 32'd0);
      check("ar_haz_b", 32'(hazard_b), 32'd0);
      reset_n = 1'b1;
      tick();

`ifdef DEST_REG_TRACKER_STATS_EN
      #1 check("st_after_reset", hazard_cycles, 32'd0);
`endif
      src_a = 5'd20; src_b = '0;
      issue(5'd20); tick();
      issue(5'd21); tick();
      issue(5'd22); tick();
      idle();
      #1 check("st_c3_haz_a", 32'(hazard_a), 32'd1);
`ifdef DEST_REG_TRACKER_STATS_EN
      check("st_count", hazard_cycles, 32'd2);
`endif
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/dest_reg_tracker.md
Name: dest_reg_tracker

Overview:
- Parametrised successor to the combinational destination-register selector.
- Selects the write destination each issue cycle: rt, rd, link register, or none.
- Carries the destination through a DEPTH-stage valid/address pipeline to writeback.
- Flags read-after-write hazards for the two source operands of the instruction in decode.
- Sits between decode and the register file; drives the stall logic and the writeback address.

Parameters:
REG_ADDR_W, 5, register address width
DEPTH, 3, pipeline stages from issue to writeback (>=1)
LINK_REG, 31, destination used when rd_select=2

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous active-low reset
issue_valid  input  1  decode stage presents a valid instruction
reg_write_en  input  1  instruction writes a register
read_reg_b  input  REG_ADDR_W  rt field
rtype_rd  input  REG_ADDR_W  rd field
rd_select  input  2  0=rt, 1=rd, 2=LINK_REG, 3=no write
stall  input  1  freeze pipeline
flush  input  1  kill all in-flight entries
src_a  input  REG_ADDR_W  decode source operand A (rs)
src_b  input  REG_ADDR_W  decode source operand B (rt)
write_reg_rd  output  REG_ADDR_W  combinational selected destination
hazard_a  output  1  src_a matches an in-flight destination
hazard_b  output  1  src_b matches an in-flight destination
wb_valid  output  1  stage DEPTH-1 entry valid
wb_reg  output  REG_ADDR_W  stage DEPTH-1 destination

Behaviour:
- write_reg_rd is combinational:
  - rd_select 0 -> read_reg_b; 1 -> rtype_rd; 2 -> LINK_REG; 3 -> 0.
- Entry valid bit = issue_valid & reg_write_en & (rd_select!=3) & (write_reg_rd!=0).
  - Register 0 is never tracked.
- Pipeline: stage[0..DEPTH-1], each holding {valid, reg}.
- On each rising edge with stall=0 and flush=0:
  - stage[0] <= new entry;
  - stage[i] <= stage[i-1];
  - stage[DEPTH-1] retires.
- Latency: an entry issued in cycle t appears on wb_valid/wb_reg in cycle t+DEPTH.
- stall=1, flush=0: all stages hold; the issue is not captured (decode re-presents it).
- flush=1: all valid bits clear at the edge; flush overrides stall.
  - The wb entry presented in the flush cycle is still considered written by that cycle.
- reset_n low: all valid bits clear and reg fields reset to 0 immediately (async); wb_valid=0, wb_reg=0, hazard_a=hazard_b=0.
  - Reset mid-operation discards all entries.
- hazard_a is combinational: src_a!=0 and some stage[i].valid with stage[i].reg==src_a, for i in 0..DEPTH-1.
- hazard_b: same rule for src_b.
- Hazards are independent of issue_valid and stall.
- wb_valid/wb_reg are registered outputs, driven directly from stage[DEPTH-1].
- DEPTH=1: a single stage, which is both stage 0 and the wb stage.

Optional Feature:
Macro DEST_REG_TRACKER_STATS_EN.
- Defined:
  - adds output hazard_cycles, 32 bits;
  - increments on each rising edge where (hazard_a|hazard_b) & issue_valid;
  - saturates at 32'hFFFFFFFF;
  - cleared by reset_n only (not by flush).
- Undefined: port and counter absent; all other behaviour is identical.

Test Plan (DEPTH=3, LINK_REG=31):
1. Selector: read_reg_b=5, rtype_rd=6, rd_select 0/1/2/3 -> write_reg_rd 5/6/31/0.
2. Latency: issue rd_select=1, rtype_rd=9, reg_write_en=1 at cycle 0 -> wb_valid=1, wb_reg=9 in cycle 3 only; wb_valid=0 in cycles 1-2 and 4.
3. Hazard: after issuing dest 9, src_a=9 -> hazard_a=1 for 3 cycles, then 0.
   - src_b=0 never flags.
   - A dest-0 issue never flags.
4. Stall: issue dest 7, then stall for 2 cycles -> entry holds in stage 0, hazard persists, wb_reg=7 at cycle 5.
   - An issue presented during the stall is not captured.
5. Flush: issue dests 3, 4, 5 back-to-back, assert flush with stall=1 in the next cycle -> all valids 0 after the edge, hazards clear, wb_valid=0.
6. Async reset: pulse reset_n low between edges with entries in flight -> wb_valid and hazards drop to 0 immediately.
   - With DEST_REG_TRACKER_STATS_EN: hazard_cycles reads 0 after reset and counts 2 after two hazarded issue cycles.
